// File: rtl/gpu_mem_arbiter.sv
// Two-port (GPU m0, CPU m1) arbiter for one single-ported memory with burst
// ownership via lock, round-robin tie-breaking and a starvation breaker.
module gpu_mem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_write,
  output logic              m0_gnt,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_write,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        state_dbg
);

  // Handshake: p_req/p_lock/p_addr/p_wdata/p_write are held by the requester
  // until p_gnt is seen high; p_gnt high means the access is issued to memory
  // that cycle. A read's data returns one cycle later with p_rvalid high.

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             last, last_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rv0_q, rv1_q;

  logic [1:0] req, lock, gnt;
  logic       own, oth, idle_pick, pick;

  assign req = {m1_req, m0_req};
  assign lock = {m1_lock, m0_lock};
  assign own = (state == OWN1);
  assign oth = ~own;

  always_comb begin
    gnt       = 2'b00;
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = cnt;
    idle_pick = 1'b0;
    pick      = 1'b0;
    if (!rst) begin
      case (state)
        OWN0, OWN1: begin
          if (cnt == LIMIT && req[oth]) begin
            // Forced release: non-owner wins and its lock is ignored.
            gnt       = oth ? 2'b10 : 2'b01;
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (req[own]) begin
            gnt = own ? 2'b10 : 2'b01;
            if (lock[own]) begin
              if (req[oth] && cnt != LIMIT) cnt_nxt = cnt + CNT_W'(1);
            end else begin
              state_nxt = IDLE;
              cnt_nxt   = '0;
            end
          end else begin
            // Owner went quiet: arbitrate as IDLE this very cycle.
            idle_pick = 1'b1;
          end
        end
        default: idle_pick = 1'b1;
      endcase

      if (idle_pick) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        pick      = (req == 2'b11) ? ~last : req[1];
        if (|req) begin
          gnt = pick ? 2'b10 : 2'b01;
          if (lock[pick]) state_nxt = pick ? OWN1 : OWN0;
        end
      end

      if (|gnt) last_nxt = gnt[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
      rv0_q <= 1'b0;
      rv1_q <= 1'b0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
      rv0_q <= gnt[0] & ~m0_write;
      rv1_q <= gnt[1] & ~m1_write;
    end
  end

  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_write = 1'b0;
    if (gnt[0]) begin
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
      mem_write = m0_write;
    end else if (gnt[1]) begin
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
      mem_write = m1_write;
    end
  end

  // Reset gates rvalid immediately so a read issued just before reset is dropped.
  assign m0_rvalid = rv0_q & ~rst;
  assign m1_rvalid = rv1_q & ~rst;
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

  assign state_dbg = state;

endmodule

// File: tb/tb_gpu_mem_arbiter.sv
// Directed, table-driven bench for gpu_mem_arbiter with a 1-cycle-latency
// memory model; one row per clock cycle, STARVE_LIMIT set to 4.
module tb_gpu_mem_arbiter;

  localparam int A = 32'h5A5A;  // m0 write data
  localparam int B = 32'hBEEF;  // m1 write data

  logic        clk;
  logic        rst;
  logic        m0_req, m0_lock, m0_write, m0_gnt, m0_rvalid;
  logic [15:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_lock, m1_write, m1_gnt, m1_rvalid;
  logic [15:0] m1_addr, m1_wdata, m1_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write;
  logic [1:0]  state_dbg;

  int check_cnt = 0;
  int pass_cnt  = 0;

  gpu_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_write(m0_write), .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_write(m1_write), .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .state_dbg(state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: reset reloads mem[i] = 0x1000 + i.
  logic [15:0] mem [0:255];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h1000 + 16'(i);
    end else if (mem_write) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr[7:0]];
  end

  typedef struct {
    logic        rst;
    logic        r0, l0, w0;
    logic [7:0]  a0;
    logic        r1, l1, w1;
    logic [7:0]  a1;
    logic        g0, g1, rv0, rv1;
    logic [15:0] rd0, rd1;
    logic        mw;
    logic [15:0] ma, md;
    logic [1:0]  st;
  } vec_t;

  function automatic vec_t mk(input int rst_i, r0, l0, w0, a0, r1, l1, w1, a1,
                              g0, g1, rv0, rv1, rd0, rd1, mw, ma, md, st);
    vec_t v;
    v.rst = rst_i[0]; v.r0 = r0[0]; v.l0 = l0[0]; v.w0 = w0[0]; v.a0 = a0[7:0];
    v.r1 = r1[0]; v.l1 = l1[0]; v.w1 = w1[0]; v.a1 = a1[7:0];
    v.g0 = g0[0]; v.g1 = g1[0]; v.rv0 = rv0[0]; v.rv1 = rv1[0];
    v.rd0 = rd0[15:0]; v.rd1 = rd1[15:0]; v.mw = mw[0];
    v.ma = ma[15:0]; v.md = md[15:0]; v.st = st[1:0];
    return v;
  endfunction

  // Scoreboard
  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL row %0d %s: got %h expected %h", row, name, act, exp);
  endtask

  // Driver: apply one row, check mid-cycle, advance one clock.
  task automatic run_row(input vec_t v, input int row);
    rst = v.rst;
    m0_req = v.r0; m0_lock = v.l0; m0_write = v.w0; m0_addr = {8'h00, v.a0};
    m1_req = v.r1; m1_lock = v.l1; m1_write = v.w1; m1_addr = {8'h00, v.a1};
    @(negedge clk);
    chk("m0_gnt",    row, 32'(m0_gnt),    32'(v.g0));
    chk("m1_gnt",    row, 32'(m1_gnt),    32'(v.g1));
    chk("m0_rvalid", row, 32'(m0_rvalid), 32'(v.rv0));
    chk("m1_rvalid", row, 32'(m1_rvalid), 32'(v.rv1));
    chk("m0_rdata",  row, 32'(m0_rdata),  32'(v.rd0));
    chk("m1_rdata",  row, 32'(m1_rdata),  32'(v.rd1));
    chk("mem_write", row, 32'(mem_write), 32'(v.mw));
    chk("mem_addr",  row, 32'(mem_addr),  32'(v.ma));
    chk("mem_wdata", row, 32'(mem_wdata), 32'(v.md));
    chk("state",     row, 32'(state_dbg), 32'(v.st));
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [35];

  initial begin
    // rst,r0,l0,w0,a0, r1,l1,w1,a1, g0,g1,rv0,rv1,rd0,rd1, mw,ma,md,st
    tbl[0]  = mk(1, 1,0,0,8,  1,0,0,9,  0,0,0,0,0,0,            0,0,0,0);
    // tie after reset
    tbl[1]  = mk(0, 1,0,0,8,  1,0,0,9,  1,0,0,0,0,0,            0,8,A,0);
    tbl[2]  = mk(0, 0,0,0,0,  1,0,0,9,  0,1,1,0,'h1008,0,       0,9,B,0);
    tbl[3]  = mk(0, 0,0,0,0,  0,0,0,0,  0,0,0,1,0,'h1009,       0,0,0,0);
    // alternation
    tbl[4]  = mk(0, 1,0,0,16, 1,0,0,17, 1,0,0,0,0,0,            0,16,A,0);
    tbl[5]  = mk(0, 1,0,0,16, 1,0,0,17, 0,1,1,0,'h1010,0,       0,17,B,0);
    tbl[6]  = mk(0, 1,0,0,16, 1,0,0,17, 1,0,0,1,0,'h1011,       0,16,A,0);
    tbl[7]  = mk(0, 1,0,0,16, 1,0,0,17, 0,1,1,0,'h1010,0,       0,17,B,0);
    tbl[8]  = mk(0, 1,0,0,16, 1,0,0,17, 1,0,0,1,0,'h1011,       0,16,A,0);
    tbl[9]  = mk(0, 1,0,0,16, 1,0,0,17, 0,1,1,0,'h1010,0,       0,17,B,0);
    tbl[10] = mk(0, 0,0,0,0,  0,0,0,0,  0,0,0,1,0,'h1011,       0,0,0,0);
    // write then read
    tbl[11] = mk(0, 0,0,0,0,  1,0,1,3,  0,1,0,0,0,0,            1,3,B,0);
    tbl[12] = mk(0, 1,0,0,3,  0,0,0,0,  1,0,0,0,0,0,            0,3,A,0);
    tbl[13] = mk(0, 0,0,0,0,  0,0,0,0,  0,0,1,0,'hBEEF,0,       0,0,0,0);
    // locked burst of 4 reads, m1 waiting
    tbl[14] = mk(0, 1,1,0,20, 0,0,0,0,  1,0,0,0,0,0,            0,20,A,0);
    tbl[15] = mk(0, 1,1,0,21, 1,0,0,40, 1,0,1,0,'h1014,0,       0,21,A,1);
    tbl[16] = mk(0, 1,1,0,22, 1,0,0,40, 1,0,1,0,'h1015,0,       0,22,A,1);
    tbl[17] = mk(0, 1,0,0,23, 1,0,0,40, 1,0,1,0,'h1016,0,       0,23,A,1);
    tbl[18] = mk(0, 0,0,0,0,  1,0,0,40, 0,1,1,0,'h1017,0,       0,40,B,0);
    tbl[19] = mk(0, 0,0,0,0,  0,0,0,0,  0,0,0,1,0,'h1028,       0,0,0,0);
    // starvation break after 4 waiting cycles, m1 lock ignored
    tbl[20] = mk(0, 1,1,0,50, 0,0,0,0,  1,0,0,0,0,0,            0,50,A,0);
    tbl[21] = mk(0, 1,1,0,50, 1,0,0,60, 1,0,1,0,'h1032,0,       0,50,A,1);
    tbl[22] = mk(0, 1,1,0,50, 1,0,0,60, 1,0,1,0,'h1032,0,       0,50,A,1);
    tbl[23] = mk(0, 1,1,0,50, 1,0,0,60, 1,0,1,0,'h1032,0,       0,50,A,1);
    tbl[24] = mk(0, 1,1,0,50, 1,0,0,60, 1,0,1,0,'h1032,0,       0,50,A,1);
    tbl[25] = mk(0, 1,1,0,50, 1,1,0,60, 0,1,1,0,'h1032,0,       0,60,B,1);
    tbl[26] = mk(0, 1,1,0,50, 0,0,0,0,  1,0,0,1,0,'h103C,       0,50,A,0);
    // owner drops req: other port granted in the same cycle
    tbl[27] = mk(0, 0,1,0,0,  1,0,0,61, 0,1,1,0,'h1032,0,       0,61,B,1);
    tbl[28] = mk(0, 0,0,0,0,  0,0,0,0,  0,0,0,1,0,'h103D,       0,0,0,0);
    // reset mid-burst
    tbl[29] = mk(0, 1,1,0,70, 0,0,0,0,  1,0,0,0,0,0,            0,70,A,0);
    tbl[30] = mk(0, 1,1,0,71, 1,0,0,72, 1,0,1,0,'h1046,0,       0,71,A,1);
    tbl[31] = mk(1, 1,1,0,73, 1,0,0,72, 0,0,0,0,0,0,            0,0,0,1);
    tbl[32] = mk(0, 1,0,0,73, 1,0,0,72, 1,0,0,0,0,0,            0,73,A,0);
    tbl[33] = mk(0, 0,0,0,0,  1,0,0,72, 0,1,1,0,'h1049,0,       0,72,B,0);
    tbl[34] = mk(0, 0,0,0,0,  0,0,0,0,  0,0,0,1,0,'h1048,       0,0,0,0);

    rst = 1'b1;
    m0_req = 1'b0; m0_lock = 1'b0; m0_write = 1'b0; m0_addr = '0; m0_wdata = 16'h5A5A;
    m1_req = 1'b0; m1_lock = 1'b0; m1_write = 1'b0; m1_addr = '0; m1_wdata = 16'hBEEF;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 35; i++) run_row(tbl[i], i);

    // Forced release wins over an owner lock=0 grant on the same cycle.
    run_row(mk(0, 1,1,0,80, 0,0,0,0,  1,0,0,0,0,0,          0,80,A,0), 100);
    for (int i = 0; i < 4; i++)
      run_row(mk(0, 1,1,0,80, 1,0,0,81, 1,0,1,0,'h1050,0,   0,80,A,1), 101 + i);
    run_row(mk(0, 1,0,0,80, 1,1,0,81, 0,1,1,0,'h1050,0,     0,81,B,1), 105);
    run_row(mk(0, 1,0,0,80, 0,0,0,0,  1,0,0,1,0,'h1051,     0,80,A,0), 106);
    run_row(mk(0, 0,0,0,0,  0,0,0,0,  0,0,1,0,'h1050,0,     0,0,0,0),  107);

    // m1 ownership, then release by dropping req with m0 waiting.
    run_row(mk(0, 0,0,0,0,  1,1,0,90, 0,1,0,0,0,0,          0,90,B,0), 108);
    run_row(mk(0, 1,0,0,91, 1,1,0,90, 0,1,0,1,0,'h105A,     0,90,B,2), 109);
    run_row(mk(0, 1,0,0,91, 0,0,0,0,  1,0,0,1,0,'h105A,     0,91,A,2), 110);
    run_row(mk(0, 0,0,0,0,  0,0,0,0,  0,0,1,0,'h105B,0,     0,0,0,0),  111);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
